// File: rtl/spi_slave_bridge.sv
// spi_slave_bridge: SPI mode-0 slave turning 8-bit frames into parallel register writes and prefetched reads.
module spi_slave_bridge #(
  parameter int AddrWidth = 4
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 SCK_i,
  input  logic                 MOSI_i,
  output logic                 MISO_o,
  input  logic                 CS_n_i,
  output logic [AddrWidth-1:0] Addr_o,
  output logic [7:0]           WrData_o,
  output logic                 WrStrobe_o,
  output logic                 RdStrobe_o,
  input  logic [7:0]           RdData_i,
  output logic                 Busy_o
);
  typedef enum logic [2:0] {WAITIDLE, IDLE, CMD, WR, RD} state_t;
  state_t state, state_nx;
  logic [1:0] sck_s, mosi_s, cs_s;
  logic       sck_d;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] tx;
  logic       miso_r, rd_pre, rd_pend;
  logic       cs_n, rise, fall, active, done;
  logic [7:0] byte_in;
  assign cs_n    = cs_s[1];
  assign rise    = sck_s[1] & ~sck_d;
  assign fall    = ~sck_s[1] & sck_d;
  assign active  = (state inside {CMD, WR, RD}) && !cs_n;
  assign done    = active && rise && (cnt == 3'd7);
  assign byte_in = {rx, mosi_s[1]};
  assign Busy_o  = state inside {CMD, WR, RD};
  assign MISO_o  = miso_r && (state == RD) && !cs_n;
  always_comb begin
    state_nx = state;
    case (state)
      WAITIDLE: state_nx = cs_n ? IDLE : WAITIDLE;
      IDLE:     state_nx = cs_n ? IDLE : CMD;
      default:  state_nx = cs_n ? IDLE : (done && state == CMD) ? (byte_in[7] ? RD : WR) : state;
    endcase
  end
  // CS synchronizer resets to "selected" so a frame already in progress at reset is never picked up
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      sck_s      <= 2'b00;
      mosi_s     <= 2'b00;
      cs_s       <= 2'b00;
      sck_d      <= 1'b0;
      state      <= WAITIDLE;
      cnt        <= 3'd0;
      rx         <= 7'd0;
      tx         <= 8'd0;
      miso_r     <= 1'b0;
      rd_pre     <= 1'b0;
      rd_pend    <= 1'b0;
      Addr_o     <= '0;
      WrData_o   <= 8'd0;
      WrStrobe_o <= 1'b0;
      RdStrobe_o <= 1'b0;
    end else begin
      sck_s      <= {sck_s[0], SCK_i};
      mosi_s     <= {mosi_s[0], MOSI_i};
      cs_s       <= {cs_s[0], CS_n_i};
      sck_d      <= sck_s[1];
      state      <= state_nx;
      WrStrobe_o <= done && state == WR;
      rd_pre     <= done && state == RD;
      RdStrobe_o <= (done && state == CMD && byte_in[7]) || rd_pre;
      rd_pend    <= RdStrobe_o;
      if (state == IDLE) cnt <= 3'd0;
      else if (active && rise) begin
        cnt <= cnt + 3'd1;
        rx  <= byte_in[6:0];
      end
      if (done && state == WR) WrData_o <= byte_in;
      if (done && state == CMD) Addr_o <= byte_in[AddrWidth-1:0];
      else if (WrStrobe_o || (done && state == RD)) Addr_o <= Addr_o + 1'b1;
      // read data lands one cycle after the strobe; falls shift it out MSB first
      if (rd_pend) tx <= RdData_i;
      else if (active && fall && state == RD) {miso_r, tx} <= {tx, 1'b0};
      else if (state != RD) miso_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_slave_bridge.sv
// tb_spi_slave_bridge: directed vector table plus corner-case sequences for spi_slave_bridge.
module tb_spi_slave_bridge;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic miso, wr_strobe, rd_strobe, busy;
  logic [3:0] addr;
  logic [7:0] wr_data, rd_data;
  int checks = 0, errors = 0;
  logic [7:0] wa[0:63], wd[0:63], ra[0:63];
  int nw = 0, nr = 0;
  typedef struct {
    logic [7:0] cmd, d0, d1;
    int n_wr, n_rd;
    logic [7:0] a0, a1, a2, v0, v1;
  } vec_t;
  vec_t vt[5];
  always #5 clk = ~clk;
  assign rd_data = 8'hC0 | {4'h0, addr};
  spi_slave_bridge #(.AddrWidth(4)) dut (
    .Clk_i(clk), .Reset_i(rst), .SCK_i(sck), .MOSI_i(mosi), .MISO_o(miso),
    .CS_n_i(cs_n), .Addr_o(addr), .WrData_o(wr_data), .WrStrobe_o(wr_strobe),
    .RdStrobe_o(rd_strobe), .RdData_i(rd_data), .Busy_o(busy)
  );
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (nw < 64) begin
        wa[nw] = {4'h0, addr};
        wd[nw] = wr_data;
      end
      nw++;
    end
    if (rd_strobe) begin
      if (nr < 64) ra[nr] = {4'h0, addr};
      nr++;
    end
    if (wr_strobe && rd_strobe) begin
      errors++;
      $display("FAIL strobe_overlap: both strobes high at %0t", $time);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bit_x(input logic b, input int h, output logic r);
    mosi = b;
    repeat (h) @(negedge clk);
    sck = 1'b1;
    r = miso;
    repeat (h) @(negedge clk);
    sck = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] b, input int h, output logic [7:0] r);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], h, t);
      r[i] = t;
    end
  endtask
  task automatic cs_low(input int h);
    cs_n = 1'b0;
    repeat (h) @(negedge clk);
  endtask
  task automatic cs_high(input int h);
    repeat (h) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    logic [7:0] r0, r1, rc;
    logic t;
    int bw, br;
    vt[0] = '{8'h03, 8'hA5, 8'h5A, 2, 0, 8'd3,  8'd4,  8'd0, 8'hA5, 8'h5A};
    vt[1] = '{8'h8E, 8'h00, 8'h00, 0, 3, 8'd14, 8'd15, 8'd0, 8'hCE, 8'hCF};
    vt[2] = '{8'h0F, 8'h11, 8'h22, 2, 0, 8'd15, 8'd0,  8'd0, 8'h11, 8'h22};
    vt[3] = '{8'hF3, 8'hFF, 8'h00, 0, 3, 8'd3,  8'd4,  8'd5, 8'hC3, 8'hC4};
    vt[4] = '{8'h70, 8'h3C, 8'hC3, 2, 0, 8'd0,  8'd1,  8'd0, 8'h3C, 8'hC3};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {miso, addr, wr_data, wr_strobe, rd_strobe, busy}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int v = 0; v < 5; v++) begin
      bw = nw;
      br = nr;
      cs_low(8);
      chk($sformatf("v%0d_busy", v), busy, 1);
      xfer(vt[v].cmd, 8, rc);
      xfer(vt[v].d0, 8, r0);
      xfer(vt[v].d1, 8, r1);
      cs_high(8);
      chk($sformatf("v%0d_n_wr", v), nw - bw, vt[v].n_wr);
      chk($sformatf("v%0d_n_rd", v), nr - br, vt[v].n_rd);
      chk($sformatf("v%0d_miso_cmd", v), rc, 0);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      if (vt[v].n_wr == 2) begin
        chk($sformatf("v%0d_wa0", v), wa[bw], vt[v].a0);
        chk($sformatf("v%0d_wa1", v), wa[bw+1], vt[v].a1);
        chk($sformatf("v%0d_wd0", v), wd[bw], vt[v].v0);
        chk($sformatf("v%0d_wd1", v), wd[bw+1], vt[v].v1);
        chk($sformatf("v%0d_miso_wr", v), {r0, r1}, 0);
      end else begin
        chk($sformatf("v%0d_ra0", v), ra[br], vt[v].a0);
        chk($sformatf("v%0d_ra1", v), ra[br+1], vt[v].a1);
        chk($sformatf("v%0d_ra2", v), ra[br+2], vt[v].a2);
        chk($sformatf("v%0d_rx0", v), r0, vt[v].v0);
        chk($sformatf("v%0d_rx1", v), r1, vt[v].v1);
      end
    end
    bw = nw;
    cs_low(8);
    xfer(8'h02, 8, rc);
    for (int i = 0; i < 5; i++) bit_x(1'b1, 8, t);
    cs_high(8);
    chk("abort_n_wr", nw - bw, 0);
    chk("abort_busy", busy, 0);
    chk("abort_miso", miso, 0);
    cs_low(8);
    xfer(8'h02, 8, rc);
    xfer(8'h99, 8, r0);
    cs_high(8);
    chk("after_abort_n_wr", nw - bw, 1);
    chk("after_abort_addr", wa[bw], 8'd2);
    chk("after_abort_data", wd[bw], 8'h99);
    cs_low(8);
    xfer(8'h85, 8, rc);
    for (int i = 0; i < 3; i++) bit_x(1'b0, 8, t);
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {miso, addr, wr_data, wr_strobe, rd_strobe, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bw = nw;
    br = nr;
    repeat (8) @(negedge clk);
    sck = 1'b0;
    for (int i = 0; i < 4; i++) bit_x(1'b1, 8, t);
    xfer(8'h81, 8, r0);
    chk("midreset_miso", r0, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_strobes", (nw - bw) + (nr - br), 0);
    cs_high(8);
    cs_low(8);
    xfer(8'h01, 8, rc);
    xfer(8'h77, 8, r0);
    cs_high(8);
    chk("postreset_n_wr", nw - bw, 1);
    chk("postreset_n_rd", nr - br, 0);
    chk("postreset_addr", wa[bw], 8'd1);
    chk("postreset_data", wd[bw], 8'h77);
    br = nr;
    cs_low(4);
    xfer(8'h85, 4, rc);
    for (int k = 0; k < 16; k++) begin
      xfer(8'h00, 4, r0);
      chk($sformatf("fast_rx%0d", k), r0, 8'hC0 + ((5 + k) % 16));
    end
    cs_high(4);
    chk("fast_n_rd", nr - br, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
